// File: rtl/board_pkg.sv
// Shared constants, types and scheduler state encoding for the snake board memory scheduler.
package board_pkg;

  localparam int unsigned H_DISPLAY    = 640;
  localparam int unsigned V_DISPLAY    = 480;
  localparam int unsigned BOARD_ADDR_W = 8;
  localparam int unsigned CELL_W       = 4;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RUN
  } sched_state_t;

endpackage

// File: rtl/board_mem_scheduler_if.sv
// Single-port board RAM bus: master drives the port, slave is the RAM.
interface board_mem_scheduler_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 4
);

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/board_mem_scheduler_step_scheduler.sv
// Frame tick from the beam position and a game-step scheduler with sticky overrun detection.
module step_scheduler #(
  parameter int unsigned V_DISPLAY = board_pkg::V_DISPLAY,
  parameter int unsigned SPEED_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         px,
  input  logic [9:0]         py,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  input  logic               step_done,
  output logic               frame_tick,
  output logic               step_start,
  output logic               overrun
);

  import board_pkg::*;

  localparam logic [9:0] VBlankLine = 10'(V_DISPLAY);

  sched_state_t       state;
  logic [SPEED_W-1:0] cnt;
  logic               tick_hit;

  assign tick_hit = (px == 10'd0) && (py == VBlankLine);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_tick <= 1'b0;
      step_start <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_tick <= tick_hit;
      step_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            cnt   <= speed;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (frame_tick) begin
            if (cnt == '0) begin
              step_start <= 1'b1;
              state      <= RUN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        RUN: begin
          // step_done beats a coincident frame_tick; that tick is neither counted nor an overrun.
          if (!enable) begin
            state <= IDLE;
          end else if (step_done) begin
            cnt   <= speed;
            state <= COUNT;
          end else if (frame_tick && (cnt == '0)) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_mem_scheduler.sv
// Board RAM owner: renderer/game arbitration, read return and game-step scheduling.
// Define ARB_HBLANK_EN to also grant the game during horizontal blank of visible lines.
module board_mem_scheduler #(
  parameter int unsigned ADDR_W    = board_pkg::BOARD_ADDR_W,
  parameter int unsigned DATA_W    = board_pkg::CELL_W,
  parameter int unsigned H_DISPLAY = board_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY = board_pkg::V_DISPLAY,
  parameter int unsigned SPEED_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            px,
  input  logic [9:0]            py,
  input  logic                  enable,
  input  logic [SPEED_W-1:0]    speed,
  output logic                  frame_tick,
  output logic                  step_start,
  input  logic                  step_done,
  output logic                  overrun,
  input  logic                  ren_req,
  input  logic [ADDR_W-1:0]     ren_addr,
  output logic                  ren_gnt,
  output logic                  ren_rvalid,
  input  logic                  game_req,
  input  logic                  game_we,
  input  logic [ADDR_W-1:0]     game_addr,
  input  logic [DATA_W-1:0]     game_wdata,
  output logic                  game_gnt,
  output logic                  game_rvalid,
  output logic [DATA_W-1:0]     rdata,
  board_mem_scheduler_if.master mem
);

  import board_pkg::*;

  localparam logic [9:0] VisLines = 10'(V_DISPLAY);
  localparam logic [9:0] VisPix   = 10'(H_DISPLAY);

  logic              vis;
  logic              game_win;
  logic              ren_rv_q;
  logic              game_rv_q;
  logic [DATA_W-1:0] rdata_q;

  assign vis = (py < VisLines);

`ifdef ARB_HBLANK_EN
  assign game_win = !vis || (px >= VisPix);
`else
  assign game_win = !vis;
`endif

  // Grants are masked during reset so no RAM access, write or otherwise, happens in that cycle.
  assign ren_gnt  = ren_req && !rst;
  assign game_gnt = game_req && !ren_req && game_win && !rst;

  assign mem.mem_en    = ren_gnt || game_gnt;
  assign mem.mem_we    = game_gnt && game_we;
  assign mem.mem_addr  = ren_gnt ? ren_addr : (game_gnt ? game_addr : '0);
  assign mem.mem_wdata = game_gnt ? game_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ren_rv_q  <= 1'b0;
      game_rv_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ren_rv_q  <= ren_gnt;
      game_rv_q <= game_gnt && !game_we;
      if (ren_rv_q || game_rv_q) begin
        rdata_q <= mem.mem_rdata;
      end
    end
  end

  // Return data passes straight through in the valid cycle and is held from rdata_q afterwards.
  assign ren_rvalid  = ren_rv_q && !rst;
  assign game_rvalid = game_rv_q && !rst;
  assign rdata       = rst ? '0 : ((ren_rv_q || game_rv_q) ? mem.mem_rdata : rdata_q);

  step_scheduler #(
    .V_DISPLAY (V_DISPLAY),
    .SPEED_W   (SPEED_W)
  ) u_step_scheduler (
    .clk        (clk),
    .rst        (rst),
    .px         (px),
    .py         (py),
    .enable     (enable),
    .speed      (speed),
    .step_done  (step_done),
    .frame_tick (frame_tick),
    .step_start (step_start),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_board_mem_scheduler.sv
// Directed bench for board_mem_scheduler: step scheduling, overrun, arbitration, read return, reset.
module tb_board_mem_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] px, py;
  logic       enable = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       frame_tick, step_start, step_done, overrun;
  logic       ren_req = 1'b0;
  logic [7:0] ren_addr = 8'h00;
  logic       ren_gnt, ren_rvalid;
  logic       game_req = 1'b0, game_we = 1'b0;
  logic [7:0] game_addr = 8'h00;
  logic [3:0] game_wdata = 4'h0;
  logic       game_gnt, game_rvalid;
  logic [3:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Compressed beam: 20-pixel lines, py cycling 475..484, so px==0/py==480 once per 200 clocks.
  logic       beam_free = 1'b1;
  logic [9:0] bx = 10'd0, by = 10'd475;
  logic [9:0] fpx = 10'd0, fpy = 10'd0;

  logic       auto_done = 1'b0, done_auto = 1'b0, done_man = 1'b0;
  int         dcnt = 0;

  logic       clr_mon = 1'b0;
  logic       prev_tick = 1'b0;
  int         ticks = 0, starts = 0, align_err = 0;
  logic [31:0] start_mask = 0;

  logic [3:0] ram [256];

`ifdef ARB_HBLANK_EN
  localparam logic HbExp = 1'b1;
`else
  localparam logic HbExp = 1'b0;
`endif

  board_mem_scheduler_if #(.ADDR_W(8), .DATA_W(4)) mem_bus ();

  board_mem_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .px          (px),
    .py          (py),
    .enable      (enable),
    .speed       (speed),
    .frame_tick  (frame_tick),
    .step_start  (step_start),
    .step_done   (step_done),
    .overrun     (overrun),
    .ren_req     (ren_req),
    .ren_addr    (ren_addr),
    .ren_gnt     (ren_gnt),
    .ren_rvalid  (ren_rvalid),
    .game_req    (game_req),
    .game_we     (game_we),
    .game_addr   (game_addr),
    .game_wdata  (game_wdata),
    .game_gnt    (game_gnt),
    .game_rvalid (game_rvalid),
    .rdata       (rdata),
    .mem         (mem_bus.master)
  );

  always #5 clk = ~clk;

  assign px        = beam_free ? bx : fpx;
  assign py        = beam_free ? by : fpy;
  assign step_done = done_auto | done_man;

  always @(posedge clk) begin
    if (bx == 10'd19) begin
      bx <= 10'd0;
      by <= (by == 10'd484) ? 10'd475 : by + 10'd1;
    end else begin
      bx <= bx + 10'd1;
    end
  end

  // Synchronous RAM model: read data appears the cycle after mem_en.
  initial mem_bus.mem_rdata = 4'h0;
  always @(posedge clk) begin
    if (mem_bus.mem_en) begin
      if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
    end
  end

  // Game-engine model: answers each step_start with a step_done 100 clocks later.
  always @(negedge clk) begin
    if (!auto_done) begin
      done_auto <= 1'b0;
      dcnt      <= 0;
    end else if (step_start) begin
      done_auto <= 1'b0;
      dcnt      <= 100;
    end else if (dcnt == 1) begin
      done_auto <= 1'b1;
      dcnt      <= 0;
    end else begin
      done_auto <= 1'b0;
      if (dcnt != 0) dcnt <= dcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      ticks      <= 0;
      starts     <= 0;
      align_err  <= 0;
      start_mask <= 0;
    end else begin
      if (frame_tick) ticks <= ticks + 1;
      if (step_start) begin
        starts <= starts + 1;
        if (!prev_tick) align_err <= align_err + 1;
        if (ticks < 32) start_mask <= start_mask | (32'd1 << ticks);
      end
    end
    prev_tick <= frame_tick;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    cyc(1);
    clr_mon = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < n * 300) begin
      @(negedge clk);
      budget++;
      if (frame_tick) seen++;
    end
    check_eq("tick_wait", seen, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    auto_done = 1'b0;
    cyc(3);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 4'h0;

    // Reset state
    cyc(2);
    #2;
    check_eq("rst_frame_tick", frame_tick, 0);
    check_eq("rst_step_start", step_start, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_mem_en", mem_bus.mem_en, 0);
    rst = 1'b0;

    // speed=0: one step per tick, one cycle after it, no overrun
    speed = 4'd0; enable = 1'b1; auto_done = 1'b1;
    clear_mon();
    wait_ticks(5);
    cyc(3);
    check_eq("s0_ticks", ticks, 5);
    check_eq("s0_starts", starts, 5);
    check_eq("s0_align", align_err, 0);
    check_eq("s0_overrun", overrun, 0);

    // speed=2: steps on ticks 3, 6, 9
    do_reset();
    speed = 4'd2; enable = 1'b1; auto_done = 1'b1;
    clear_mon();
    wait_ticks(9);
    cyc(3);
    check_eq("s2_starts", starts, 3);
    check_eq("s2_mask", start_mask, 32'h0000_0248);
    check_eq("s2_overrun", overrun, 0);

    // step_done withheld: overrun on the first due tick, no extra step_start
    do_reset();
    speed = 4'd0; enable = 1'b1;
    clear_mon();
    wait_ticks(1);
    cyc(3);
    check_eq("ov_first_start", starts, 1);
    check_eq("ov_pre", overrun, 0);
    wait_ticks(1);
    cyc(2);
    check_eq("ov_set", overrun, 1);
    check_eq("ov_no_start", starts, 1);
    wait_ticks(1);
    cyc(2);
    check_eq("ov_no_start2", starts, 1);
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    wait_ticks(1);
    cyc(3);
    check_eq("ov_resume", starts, 2);
    check_eq("ov_sticky", overrun, 1);

    // Arbitration and read return with a hand-driven beam
    enable = 1'b0; beam_free = 1'b0;
    cyc(1);
    fpy = 10'd100; fpx = 10'd10;
    ren_req = 1'b1; ren_addr = 8'h11;
    game_req = 1'b1; game_we = 1'b1; game_addr = 8'h23; game_wdata = 4'h5;
    #2;
    check_eq("vis_ren_gnt", ren_gnt, 1);
    check_eq("vis_game_gnt", game_gnt, 0);
    check_eq("vis_mem_we", mem_bus.mem_we, 0);
    check_eq("vis_mem_addr", mem_bus.mem_addr, 8'h11);
    cyc(1);
    ren_req = 1'b0; fpy = 10'd500;
    #2;
    check_eq("ren_rvalid", ren_rvalid, 1);
    check_eq("wr_game_gnt", game_gnt, 1);
    check_eq("wr_mem_we", mem_bus.mem_we, 1);
    check_eq("wr_mem_addr", mem_bus.mem_addr, 8'h23);
    check_eq("wr_mem_wdata", mem_bus.mem_wdata, 4'h5);
    cyc(1);
    game_we = 1'b0;
    #2;
    check_eq("rd_game_gnt", game_gnt, 1);
    check_eq("rd_mem_we", mem_bus.mem_we, 0);
    check_eq("wr_no_rvalid", game_rvalid, 0);
    check_eq("ren_rvalid_once", ren_rvalid, 0);
    cyc(1);
    game_req = 1'b0;
    #2;
    check_eq("rd_game_rvalid", game_rvalid, 1);
    check_eq("rd_rdata", rdata, 4'h5);
    cyc(1);
    #2;
    check_eq("rd_rvalid_drop", game_rvalid, 0);
    check_eq("rd_rdata_hold", rdata, 4'h5);

    // Renderer read during a visible line
    fpy = 10'd100; ren_req = 1'b1; ren_addr = 8'h23;
    cyc(1);
    ren_req = 1'b0;
    #2;
    check_eq("ren_rd_rvalid", ren_rvalid, 1);
    check_eq("ren_rd_rdata", rdata, 4'h5);
    check_eq("ren_rd_game_rv", game_rvalid, 0);

    // Horizontal blank window and vertical boundary
    cyc(1);
    fpy = 10'd100; fpx = 10'd700; game_req = 1'b1; game_we = 1'b0;
    #2;
    check_eq("hblank_gnt", game_gnt, HbExp);
    fpx = 10'd10;
    #1;
    check_eq("vis_px10_gnt", game_gnt, 0);
    fpy = 10'd479;
    #1;
    check_eq("py479_gnt", game_gnt, 0);
    fpy = 10'd480;
    #1;
    check_eq("py480_gnt", game_gnt, 1);

    // frame_tick registered one cycle after px==0, py==480
    cyc(1);
    game_req = 1'b0; fpx = 10'd0; fpy = 10'd480;
    #2;
    check_eq("ft_pre", frame_tick, 0);
    cyc(1);
    fpx = 10'd1;
    #2;
    check_eq("ft_pulse", frame_tick, 1);
    cyc(1);
    #2;
    check_eq("ft_width", frame_tick, 0);

    // Reset the cycle after a granted read; a write request during reset must not reach the RAM
    fpy = 10'd500; fpx = 10'd10;
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'h23;
    #2;
    check_eq("rr_gnt", game_gnt, 1);
    cyc(1);
    rst = 1'b1; game_we = 1'b1; game_wdata = 4'hA;
    #2;
    check_eq("rr_rvalid", game_rvalid, 0);
    check_eq("rr_mem_en", mem_bus.mem_en, 0);
    check_eq("rr_mem_we", mem_bus.mem_we, 0);
    check_eq("rr_game_gnt", game_gnt, 0);
    check_eq("rr_rdata", rdata, 0);
    cyc(1);
    #2;
    check_eq("rr_overrun", overrun, 0);
    check_eq("rr_step_start", step_start, 0);
    check_eq("rr_frame_tick", frame_tick, 0);
    check_eq("rr_ram_intact", ram[8'h23], 4'h5);
    rst = 1'b0; game_req = 1'b0; game_we = 1'b0;

    // After reset the FSM starts in IDLE and schedules on the first tick once enabled
    beam_free = 1'b1; speed = 4'd0; enable = 1'b1; auto_done = 1'b1;
    clear_mon();
    wait_ticks(1);
    cyc(3);
    check_eq("post_rst_start", starts, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_mem_scheduler.md
Name: board_mem_scheduler

Overview:
- Owns the single-port board RAM and its frame-level timing for the snake game.
- Arbitrates RAM access between the pixel renderer (hard real-time) and the game-logic engine.
- Derives a frame tick from the VGA beam position and schedules one game-logic step every N frames via a start/done handshake.
- Sits between the VGA sync generator, the renderer, the game engine and the board RAM.

Parameters:
- ADDR_W, 8, board RAM address width (16x16 cells).
- DATA_W, 4, board RAM data width (cell code).
- H_DISPLAY, 640, visible pixels per line; must match the sync generator.
- V_DISPLAY, 480, visible lines per frame; must match the sync generator.
- SPEED_W, 4, width of the frames-per-step setting.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- px  in  10  current beam x from the sync generator
- py  in  10  current beam y from the sync generator
- enable  in  1  game running; when low, no steps are scheduled
- speed  in  SPEED_W  frames per step, minus 1 (0 = every frame)
- frame_tick  out  1  one-cycle pulse at the start of vertical blank
- step_start  out  1  one-cycle pulse: game engine must run one step
- step_done  in  1  one-cycle pulse from the game engine: step finished
- overrun  out  1  sticky: a step was due while the previous step was still running
- ren_req, ren_addr[ADDR_W]  in  renderer read request
- ren_gnt  out  1  renderer request accepted this cycle
- ren_rvalid  out  1  renderer read data valid on rdata
- game_req, game_we  in  1  game request; 1 = write
- game_addr[ADDR_W], game_wdata[DATA_W]  in  game address and write data
- game_gnt  out  1  game request accepted this cycle
- game_rvalid  out  1  game read data valid on rdata
- rdata  out  DATA_W  registered copy of mem_rdata
- mem_en, mem_we  out  1  RAM port enable and write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en

Behaviour:
- Reset: every output is 0; FSM is IDLE; frame counter is 0; overrun is cleared.
- frame_tick:
  - Registered; high in the cycle after the inputs show px==0 && py==V_DISPLAY.
  - Because px advances every clock, it is exactly one cycle wide.
- Scheduler FSM states: IDLE, COUNT, RUN.
  - IDLE: when enable=1, load cnt=speed and go to COUNT.
  - COUNT:
    - On frame_tick with cnt==0: pulse step_start for one cycle and go to RUN.
    - On frame_tick with cnt!=0: decrement cnt.
  - RUN: on step_done, reload cnt=speed and go to COUNT.
  - enable=0 in COUNT or RUN returns to IDLE. In RUN, an outstanding step_done is then ignored.
  - Overrun: frame_tick arriving in RUN with a step due (cnt==0) sets overrun. State stays RUN; no extra step_start is issued. overrun clears only on rst.
  - step_done and frame_tick in the same cycle while in RUN: step_done wins, go to COUNT with cnt=speed. That frame_tick is not counted and does not set overrun.
  - speed is sampled only at reload, never mid-count.
- Render window: vis = (py < V_DISPLAY).
- Arbitration (combinational, fixed priority):
  - ren_gnt = ren_req.
  - game_gnt = game_req && !ren_req && !vis.
  - The game is locked out for all visible lines, including their horizontal blanking.
- RAM port:
  - mem_en = ren_gnt | game_gnt.
  - mem_addr and mem_wdata mux to the winner.
  - mem_we = game_gnt && game_we.
  - The renderer never writes.
- Read return:
  - ren_rvalid / game_rvalid assert exactly one cycle after a granted read.
  - rdata is registered from mem_rdata in that same cycle; it is held otherwise.
  - Game writes produce no rvalid.
- Simultaneous ren_req and game_req: the renderer is served. The game request must stay asserted and unchanged until granted; no starvation guarantee while vis=1.
- Reset mid-transaction: a pending rvalid is dropped. No RAM write occurs in the reset cycle, because mem_en is forced to 0 while rst=1.

Optional Feature:
- Macro: ARB_HBLANK_EN.
- Defined: the game may also be granted on visible lines while px >= H_DISPLAY, i.e. game_gnt = game_req && !ren_req && (!vis || px >= H_DISPLAY). The renderer keeps priority.
- Undefined: game access during vertical blank only, as above.

Decomposition:
- Shared package board_pkg holds:
  - constants H_DISPLAY, V_DISPLAY, BOARD_ADDR_W, CELL_W;
  - typedef cell_t (logic [CELL_W-1:0]);
  - enum sched_state_t {IDLE, COUNT, RUN}.
- One natural sub-module: step_scheduler, containing the frame_tick generation, the FSM and overrun. The arbiter and RAM mux stay in the top module.

Test Plan:
- Reset, then enable=1, speed=0, step_done returned 100 cycles after each step_start -> one step_start per frame_tick, each one cycle after its tick; overrun stays 0.
- speed=2 over 9 frames -> exactly 3 step_start pulses, on ticks 3, 6 and 9.
- step_done withheld across two due ticks -> overrun=1 from the first due tick; no second step_start; step_done then returns the FSM to COUNT.
- At py=100, px=10, ren_req and game_req both high -> ren_gnt=1, game_gnt=0, mem_we=0. At py=500 with ren_req=0 -> game_gnt=1; a write of addr 0x23, data 0x5 gives mem_we=1; a following read gives game_rvalid one cycle later with rdata=0x5.
- ARB_HBLANK_EN: at py=100, px=700, ren_req=0, game_req=1 -> game_gnt=1 when defined, 0 when undefined.
- rst asserted the cycle after a granted read -> no rvalid; all outputs 0; FSM IDLE.
